// File: rtl/board_reset_seq.sv
// Board reset/boot sequencer: power-on hold, debounced push-button reset,
// minimum-width release hold and optional watchdog re-reset for the SoC.
module board_reset_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned POR_CYCLES      = 65536,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned WDT_CYCLES      = 0
) (
  input  logic       clk_25mhz,
  input  logic       reset_n,
  input  logic       btn_raw,
  input  logic       wd_kick,
  output logic       soc_reset,
  output logic [1:0] status,
  output logic       wdt_fired,
  output logic [7:0] reset_count
);

  localparam int unsigned CW = 24;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WDT_LAST  = CW'(WDT_CYCLES - 1);
  localparam bit            WDT_EN    = (WDT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_RUN  = 2'd1,
    ST_BTN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t          state;
  logic            btn_meta;
  logic            btn_sync;
  logic            btn_stable;
  logic [CW-1:0]   db_cnt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   wdt_cnt;

  assign status = state;

  // Synchronizer and debouncer: a level change is accepted after
  // DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      btn_stable <= 1'b0;
      db_cnt     <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      if (btn_sync == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DEB_LAST) begin
        btn_stable <= ~btn_stable;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  // Sequencer: soc_reset is registered alongside the state so it is low only in RUN.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_POR;
      soc_reset   <= 1'b1;
      cnt         <= '0;
      wdt_cnt     <= '0;
      wdt_fired   <= 1'b0;
      reset_count <= '0;
    end else begin
      case (state)
        ST_POR: begin
          wdt_cnt <= '0;
          if (cnt == POR_LAST) begin
            cnt <= '0;
            if (btn_stable) begin
              state <= ST_BTN;
            end else begin
              state     <= ST_RUN;
              soc_reset <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (btn_stable) begin
            state     <= ST_BTN;
            soc_reset <= 1'b1;
            cnt       <= '0;
            wdt_cnt   <= '0;
            if (reset_count != 8'hFF) reset_count <= reset_count + 8'd1;
          end else if (WDT_EN) begin
            // A kick in the terminal cycle wins over the timeout.
            if (wd_kick) begin
              wdt_cnt <= '0;
            end else if (wdt_cnt == WDT_LAST) begin
              state     <= ST_HOLD;
              soc_reset <= 1'b1;
              wdt_fired <= 1'b1;
              wdt_cnt   <= '0;
              cnt       <= '0;
            end else begin
              wdt_cnt <= wdt_cnt + CW'(1);
            end
          end
        end
        ST_BTN: begin
          wdt_cnt <= '0;
          if (!btn_stable) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        ST_HOLD: begin
          wdt_cnt <= '0;
          if (btn_stable) begin
            state <= ST_BTN;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state     <= ST_RUN;
            soc_reset <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= ST_POR;
          soc_reset <= 1'b1;
          cnt       <= '0;
          wdt_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/board_reset_seq.md
# board_reset_seq

Board-level reset and boot sequencer that owns the z8086 SoC reset input on the ULX3S top. Holds the SoC in reset for a power-on interval, then converts a raw push-button into a clean, debounced, minimum-width SoC reset. Includes an optional watchdog that re-resets the SoC when software stops kicking it. Reports its state for LED display.

## Interface

Parameters:

- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized samples required to accept a button level change (10 ms at 25 MHz); must be ≥1 and <2^24.
- POR_CYCLES, 65536: SoC reset hold after `reset_n` release; must be ≥1 and <2^24.
- HOLD_CYCLES, 16: minimum SoC reset hold after a button release or watchdog fire; must be ≥1 and <2^24.
- WDT_CYCLES, 0: watchdog timeout in cycles; 0 disables the watchdog; must be <2^24.

Ports (one clock; reset is asynchronous and active-low):

- clk_25mhz, input, 1: sole clock.
- reset_n, input, 1: asynchronous active-low reset.
- btn_raw, input, 1: unsynchronized reset button, active-high.
- wd_kick, input, 1: single-cycle watchdog kick from the SoC, synchronous to `clk_25mhz`.
- soc_reset, output, 1: active-high reset to the SoC; registered.
- status, output, 2: current state, encoded as 0=POR, 1=RUN, 2=BTN, 3=HOLD.
- wdt_fired, output, 1: sticky flag, set by a watchdog timeout.
- reset_count, output, 8: saturating count of button-initiated resets.

## Operation

**Input conditioning**

- `btn_raw` passes through a 2-flop synchronizer to produce `btn_sync`.
- The debouncer keeps `btn_stable` (reset value 0) and a 24-bit counter.
- The counter clears on any cycle where `btn_sync == btn_stable`, and increments otherwise.
- When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, `btn_stable` toggles and the counter clears.

**State machine** (24-bit shared counter `cnt`, cleared on every state change):

- **POR**
  - `soc_reset=1`; `cnt` increments.
  - At `cnt==POR_CYCLES-1`: go to BTN if `btn_stable=1`, else RUN. No `reset_count` increment in either case.
- **RUN**
  - `soc_reset=0`.
  - `btn_stable=1`: go to BTN and increment `reset_count` (saturates at 255).
  - Otherwise, if WDT_CYCLES≠0: the watchdog counter increments each cycle and clears on `wd_kick`. At count WDT_CYCLES-1 with no kick in that cycle: go to HOLD and set `wdt_fired`.
  - A kick in the terminal cycle wins; no fire.
  - The button takes priority over a simultaneous watchdog timeout.
- **BTN**
  - `soc_reset=1`.
  - `btn_stable=0`: go to HOLD.
- **HOLD**
  - `soc_reset=1`; `cnt` increments.
  - `btn_stable=1`: go to BTN, no count increment.
  - At `cnt==HOLD_CYCLES-1`: go to RUN.
- The watchdog counter is cleared in every state except RUN.
- `wd_kick` is ignored outside RUN.

**Reset values** (`reset_n` low; all asynchronous):

- `soc_reset=1`, `status=0` (POR).
- `wdt_fired=0`, `reset_count=0`.
- `btn_stable=0`, synchronizer flops 0, all counters 0.

`wdt_fired` clears only on `reset_n`.

## Timing

- `soc_reset` and `status` are registered outputs of the state register, with no combinational path from inputs.
- POR: `soc_reset` falls on the POR_CYCLES-th rising edge after `reset_n` deasserts.
- Button latency:
  - `btn_raw` rise to `btn_stable` rise: 2+DEBOUNCE_CYCLES edges, given a stable input.
  - `btn_stable` to `soc_reset` high: 1 further edge.
- Release: after `btn_stable` falls, `soc_reset` stays high for exactly HOLD_CYCLES+1 edges (1 edge to enter HOLD, plus HOLD_CYCLES in HOLD).
- Watchdog: with no kicks, `soc_reset` rises WDT_CYCLES edges after entering RUN.
- `reset_count` and `wdt_fired` update on the same edge as the corresponding state transition.
- Mid-operation `reset_n` assertion forces the reset values immediately, without waiting for a clock.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, POR_CYCLES=8, HOLD_CYCLES=3, WDT_CYCLES=20 unless stated.

- **POR:** release `reset_n` with the button idle → `soc_reset=1` and `status=0` for 7 edges; on edge 8, `soc_reset=0` and `status=1`.
- **Debounce:**
  - A 3-cycle `btn_raw` pulse in RUN → no change.
  - A 10-cycle pulse → `btn_stable` rises 6 edges after onset; next edge gives `soc_reset=1`, `status=2`, `reset_count=1`.
  - On release, `status=3` for 3 cycles, then `status=1` with `soc_reset=0`.
- **Watchdog:**
  - No kick for 20 cycles in RUN → `soc_reset=1`, `status=3`, `wdt_fired=1`; back to RUN 3 cycles later, with `wdt_fired` still 1.
  - A kick every 10 cycles → never fires.
  - A kick exactly on the terminal cycle → no fire.
  - With WDT_CYCLES=0, 10000 idle cycles → no fire.
- **Button during POR and HOLD:**
  - Button held through POR end → `status` goes 0→2, `reset_count` stays 0.
  - Re-press during HOLD → `status` returns to 2, `reset_count` unchanged.
- **Asynchronous reset mid-HOLD:** drop `reset_n` between clock edges → `soc_reset=1`, `status=0`, `wdt_fired=0`, `reset_count=0` without a clock edge.
- **Saturation:** 260 debounced presses → `reset_count=255`, and each press still produces an SoC reset.
